// File: rtl/gray_count_ctrl_if.sv
// Command and status bundle for the Gray-code count controller.
// The master drives the commands and observes the count; the slave is the controller.
interface gray_count_ctrl_if #(
    parameter int unsigned N = 4
);
    logic         tick;
    logic         start;
    logic         stop;
    logic         step;
    logic         clear;
    logic         load;
    logic [N-1:0] load_val;
    logic         dir;
    logic         wrap_en;

    logic [N-1:0] gray;
    logic [N-1:0] bin;
    logic [1:0]   state;
    logic         running;
    logic         term;

    modport master (
        output tick, start, stop, step, clear, load, load_val, dir, wrap_en,
        input  gray, bin, state, running, term
    );

    modport slave (
        input  tick, start, stop, step, clear, load, load_val, dir, wrap_en,
        output gray, bin, state, running, term
    );
endinterface

// File: rtl/gray_count_ctrl.sv
// Tick-driven up/down counter with run/pause/single-step control.
// Binary and Gray views of the count are registered together so they
// always agree; term flags the cycle after a wrap or saturation.
module gray_count_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic              clk,
    input  logic              rst,
    gray_count_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_STEP  = 2'b11
    } state_t;

    state_t       st_r;
    logic [N-1:0] bin_r;
    logic [N-1:0] gray_r;
    logic         running_r;
    logic         term_r;

    logic [N-1:0] adv_val;
    logic         adv_hit;
    logic         adv_ok;

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Candidate next count for a tick, and whether that tick crosses the boundary.
    always_comb begin
        adv_val = bus.dir ? (bin_r + N'(1)) : (bin_r - N'(1));
        adv_hit = bus.dir ? (bin_r == '1) : (bin_r == '0);
        adv_ok  = bus.tick && ((st_r == S_RUN) || (st_r == S_STEP));
    end

    // Control FSM and count registers; commands are strictly prioritised
    // clear > load > stop > start > step, and a tick only acts when no
    // command has claimed the cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_r      <= S_IDLE;
            bin_r     <= '0;
            gray_r    <= '0;
            running_r <= 1'b0;
            term_r    <= 1'b0;
        end else begin
            term_r <= 1'b0;
            if (bus.clear) begin
                st_r      <= S_IDLE;
                running_r <= 1'b0;
                bin_r     <= '0;
                gray_r    <= '0;
            end else if (bus.load) begin
                bin_r  <= bus.load_val;
                gray_r <= to_gray(bus.load_val);
            end else if (bus.stop && ((st_r == S_RUN) || (st_r == S_STEP))) begin
                st_r      <= S_PAUSE;
                running_r <= 1'b0;
            end else if (bus.stop) begin
                // stop in IDLE or PAUSE is a no-op, but still outranks start/step
                st_r <= st_r;
            end else if (bus.start && (st_r != S_RUN)) begin
                st_r      <= S_RUN;
                running_r <= 1'b1;
            end else if (bus.step && ((st_r == S_IDLE) || (st_r == S_PAUSE))) begin
                st_r      <= S_STEP;
                running_r <= 1'b1;
            end else if (adv_ok) begin
                // start held in RUN or step seen in RUN/STEP falls through to here,
                // so a level-held start never blocks counting
                term_r <= adv_hit;
                if (adv_hit && !bus.wrap_en) begin
                    st_r      <= S_PAUSE;
                    running_r <= 1'b0;
                end else begin
                    bin_r  <= adv_val;
                    gray_r <= to_gray(adv_val);
                    if (st_r == S_STEP) begin
                        st_r      <= S_PAUSE;
                        running_r <= 1'b0;
                    end
                end
            end
        end
    end

    // Registered status onto the bus.
    always_comb begin
        bus.bin     = bin_r;
        bus.gray    = gray_r;
        bus.state   = st_r;
        bus.running = running_r;
        bus.term    = term_r;
    end

endmodule
